// File: rtl/sync_memory_pkg.sv
// Shared types and default sizing for the sync_memory block.
package sync_memory_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam int DEF_DW = 16;
    localparam int DEF_AW = 6;

endpackage

// File: rtl/sync_memory_if.sv
// Processor-side access bus for sync_memory.
// master: the processor issuing requests; slave: the memory.
interface sync_memory_if
    import sync_memory_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
);
    logic          Step;
    logic          req;
    logic          WrtMem;
    logic [AW-1:0] Adrs;
    logic [DW-1:0] Din;
    logic          busy;
    logic          rvalid;
    logic [DW-1:0] Dout;
    logic          perr;

    modport master (
        output Step, req, WrtMem, Adrs, Din,
        input  busy, rvalid, Dout, perr
    );

    modport slave (
        input  Step, req, WrtMem, Adrs, Din,
        output busy, rvalid, Dout, perr
    );
endinterface

// File: rtl/sync_memory_array.sv
// Single-port storage with a registered read port and a one-cycle read strobe.
// W is the stored word width, so a parity bit can ride along with the data.
module sync_memory_array #(
    parameter int W  = 16,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          rvalid
);
    logic [W-1:0] mem [2**AW];

    logic [W-1:0] rdata_q, rdata_d;
    logic         rvalid_q, rvalid_d;

    // Storage write; contents are made deterministic by the clear sequence, not by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data holds until the next read; strobe follows the read enable.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = re;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Read port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: rtl/sync_memory.sv
// Parametrised single-port memory with post-reset hardware clear.
// Optional build macro: SYNC_MEMORY_PARITY_EN adds an even-parity bit per word
// and reports perr on reads; without it the array is DW wide and perr is 0.
//
// state    | meaning
// ST_CLEAR | writing zero to mem[cnt], one word per cycle; requests dropped
// ST_IDLE  | accepting Step-qualified read/write requests
module sync_memory
    import sync_memory_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic        clk,
    input  logic        reset,
    sync_memory_if.slave bus
);
`ifdef SYNC_MEMORY_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    // One extra counter bit keeps the terminal compare free of wrap ambiguity.
    localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

    state_t        state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic          clearing;
    logic          accept;
    logic          arr_we;
    logic          arr_re;
    logic [AW-1:0] arr_addr;
    logic [MW-1:0] arr_wdata;
    logic [MW-1:0] arr_rdata;
    logic [MW-1:0] wr_word;

`ifdef SYNC_MEMORY_PARITY_EN
    assign wr_word = {^bus.Din, bus.Din};
`else
    assign wr_word = bus.Din;
`endif

    // State and clear-counter registers; reset restarts the clear from address 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk the clear counter until the last word is written.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Outputs: array port steering, request qualification and clear writes.
    always_comb begin
        clearing  = (state_q == ST_CLEAR);
        accept    = bus.req & bus.Step & ~clearing & ~reset;
        arr_we    = (clearing & ~reset) | (accept & bus.WrtMem);
        arr_re    = accept & ~bus.WrtMem;
        arr_addr  = clearing ? cnt_q[AW-1:0] : bus.Adrs;
        arr_wdata = clearing ? '0 : wr_word;
    end

    sync_memory_array #(
        .W  (MW),
        .AW (AW)
    ) u_array (
        .clk    (clk),
        .reset  (reset),
        .we     (arr_we),
        .re     (arr_re),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .rdata  (arr_rdata),
        .rvalid (bus.rvalid)
    );

    assign bus.busy = clearing;
    assign bus.Dout = arr_rdata[DW-1:0];

`ifdef SYNC_MEMORY_PARITY_EN
    // Stored parity is even, so the XOR of the whole registered word is the error flag.
    assign bus.perr = ^arr_rdata;
`else
    assign bus.perr = 1'b0;
`endif

endmodule
